pci_arbiter: RTL and testbench

PCI_ARBITER -- requirements
Module: pci_arbiter

---
 rtl/pci_arb_pkg.sv | 14 +
 rtl/pci_arbiter_rr_pick.sv | 28 ++
 rtl/pci_arbiter.sv | 98 +++++++++
 tb/tb_pci_arbiter.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/pci_arb_pkg.sv
// Shared types and default constants for the PCI bus arbiter.
package pci_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    BUSY  = 2'd2,
    TURN  = 2'd3
  } state_t;

  localparam int NREQ_DEF        = 4;
  localparam int GNT_TIMEOUT_DEF = 16;

endpackage

// File: rtl/pci_arbiter_rr_pick.sv
// Round-robin picker: searches req from last+1 (wrapping) and returns the first set bit.
module rr_pick #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last,
  output logic         valid,
  output logic [W-1:0] winner
);

  int idx;

  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
    valid  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int i = 1; i <= N; i++) begin
      idx = (int'(last) + i) % N;
      if (!valid && req[idx]) begin
        valid  = 1'b1;
        winner = W'(idx);
      end
    end
  end

endmodule

// File: rtl/pci_arbiter.sv
// PCI bus arbiter: round-robin grants, grant timeout, burst preemption and turnaround cycle.
module pci_arbiter
  import pci_arb_pkg::*;
#(
  parameter int NREQ        = NREQ_DEF,
  parameter int GNT_TIMEOUT = GNT_TIMEOUT_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         reqn,
  input  logic                    framen,
  input  logic                    irdyn,
  output logic [NREQ-1:0]         gntn,
  output logic [$clog2(NREQ)-1:0] owner,
  output logic                    bus_busy,
  output logic [1:0]              state
);

  localparam int         OW      = $clog2(NREQ);
  localparam logic [4:0] TO_LAST = 5'(GNT_TIMEOUT - 1);

  state_t          state_q;
  logic [4:0]      cnt;
  logic            pick_valid;
  logic [OW-1:0]   pick_idx;
  logic [NREQ-1:0] owner_mask;
  logic            other_req;

  rr_pick #(.N(NREQ), .W(OW)) u_pick (
    .req    (~reqn),
    .last   (owner),
    .valid  (pick_valid),
    .winner (pick_idx)
  );

  assign owner_mask = NREQ'(1) << owner;
  assign other_req  = |(~reqn & ~owner_mask);
  assign state      = state_q;

  always_ff @(posedge clk) begin
    // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q  <= IDLE;
      gntn     <= '1;
      owner    <= OW'(NREQ - 1);
      bus_busy <= 1'b0;
      cnt      <= '0;
    end else begin
      bus_busy <= ~framen | ~irdyn;
      case (state_q)
        IDLE, TURN: begin
          gntn <= '1;
          // An unsolicited transaction takes the bus without a grant and leaves owner alone.
          if (!framen) begin
            state_q <= BUSY;
          end else if (pick_valid) begin
            state_q <= GRANT;
            owner   <= pick_idx;
            gntn    <= ~(NREQ'(1) << pick_idx);
            cnt     <= '0;
          end else begin
            state_q <= IDLE;
          end
        end
        GRANT: begin
          if (!framen) begin
            state_q <= BUSY;
          end else if (reqn[owner] || cnt == TO_LAST) begin
            state_q <= TURN;
            gntn    <= '1;
          end else begin
            cnt <= cnt + 5'd1;
          end
        end
        BUSY: begin
          if (framen && irdyn) begin
            if (other_req) begin
              state_q <= TURN;
              gntn    <= '1;
            end else if (!reqn[owner]) begin
              state_q <= GRANT;
              gntn    <= ~owner_mask;
              cnt     <= '0;
            end else begin
              state_q <= IDLE;
              gntn    <= '1;
            end
          end else if (framen && other_req) begin
            // Last data phase: withdraw the grant so the owner cannot chain another burst.
            gntn <= '1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pci_arbiter.sv
// Directed self-checking bench for pci_arbiter (NREQ=4, GNT_TIMEOUT=16).
module tb_pci_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] reqn = 4'b1111;
  logic       framen = 1'b1;
  logic       irdyn = 1'b1;
  logic [3:0] gntn;
  logic [1:0] owner;
  logic       bus_busy;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;

  pci_arbiter #(.NREQ(4), .GNT_TIMEOUT(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .reqn     (reqn),
    .framen   (framen),
    .irdyn    (irdyn),
    .gntn     (gntn),
    .owner    (owner),
    .bus_busy (bus_busy),
    .state    (state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Outputs are sampled 1 ns after the rising edge; inputs change at the same point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; reqn = 4'b1111; framen = 1'b1; irdyn = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state); end
    checks++; if (gntn !== 4'b1111) begin errors++; $display("FAIL reset_gntn: got %b expected 1111", gntn); end
    checks++; if (owner !== 2'd3) begin errors++; $display("FAIL reset_owner: got %0d expected 3", owner); end
    checks++; if (bus_busy !== 1'b0) begin errors++; $display("FAIL reset_bus_busy: got %b expected 0", bus_busy); end
  endtask

  task automatic test_single();
    do_reset();
    reqn = 4'b1110;
    tick();
    checks++; if (gntn !== 4'b1110) begin errors++; $display("FAIL single_grant: got %b expected 1110", gntn); end
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL single_state_grant: got %0d expected 1", state); end
    framen = 1'b0;
    tick();
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL single_state_busy: got %0d expected 2", state); end
    tick();
    tick();
    checks++; if (gntn !== 4'b1110) begin errors++; $display("FAIL single_grant_held: got %b expected 1110", gntn); end
    checks++; if (bus_busy !== 1'b1) begin errors++; $display("FAIL single_bus_busy: got %b expected 1", bus_busy); end
    framen = 1'b1; irdyn = 1'b1; reqn = 4'b1111;
    tick();
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL single_to_idle: got %0d expected 0", state); end
    checks++; if (gntn !== 4'b1111) begin errors++; $display("FAIL single_release: got %b expected 1111", gntn); end
    checks++; if (bus_busy !== 1'b0) begin errors++; $display("FAIL single_bus_free: got %b expected 0", bus_busy); end
  endtask

  task automatic test_fairness();
    logic [3:0] exp_gnt [5] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
    do_reset();
    reqn = 4'b0000;
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++; if (gntn !== exp_gnt[k]) begin errors++; $display("FAIL fair_grant_%0d: got %b expected %b", k, gntn, exp_gnt[k]); end
      if (k < 4) begin
        framen = 1'b0;
        tick();
        tick();
        framen = 1'b1; irdyn = 1'b1;
        tick();
        checks++; if (state !== 2'd3 || gntn !== 4'b1111) begin
          errors++; $display("FAIL fair_turn_%0d: got state %0d gntn %b expected state 3 gntn 1111", k, state, gntn);
        end
      end
    end
    reqn = 4'b1111;
    tick();
    tick();
  endtask

  task automatic test_timeout();
    int low_cycles;
    do_reset();
    reqn = 4'b1011;
    tick();
    low_cycles = (gntn === 4'b1011) ? 1 : 0;
    for (int k = 0; k < 24; k++) begin
      tick();
      if (gntn === 4'b1011) low_cycles++;
      else break;
    end
    checks++; if (low_cycles != 16) begin errors++; $display("FAIL timeout_len: got %0d expected 16", low_cycles); end
    checks++; if (state !== 2'd3 || gntn !== 4'b1111) begin
      errors++; $display("FAIL timeout_turn: got state %0d gntn %b expected state 3 gntn 1111", state, gntn);
    end
    tick();
    checks++; if (gntn !== 4'b1011 || owner !== 2'd2) begin
      errors++; $display("FAIL timeout_regrant: got gntn %b owner %0d expected gntn 1011 owner 2", gntn, owner);
    end
    reqn = 4'b1111;
    tick();
    tick();
  endtask

  task automatic test_preempt();
    do_reset();
    reqn = 4'b1101;
    tick();
    framen = 1'b0;
    tick();
    checks++; if (gntn !== 4'b1101 || state !== 2'd2) begin
      errors++; $display("FAIL preempt_busy: got gntn %b state %0d expected gntn 1101 state 2", gntn, state);
    end
    reqn = 4'b0101;
    tick();
    checks++; if (gntn !== 4'b1101) begin errors++; $display("FAIL preempt_hold: got %b expected 1101", gntn); end
    framen = 1'b1; irdyn = 1'b0;
    tick();
    checks++; if (gntn !== 4'b1111 || state !== 2'd2) begin
      errors++; $display("FAIL preempt_drop: got gntn %b state %0d expected gntn 1111 state 2", gntn, state);
    end
    irdyn = 1'b1;
    tick();
    checks++; if (state !== 2'd3) begin errors++; $display("FAIL preempt_turn: got %0d expected 3", state); end
    tick();
    checks++; if (gntn !== 4'b0111 || owner !== 2'd3) begin
      errors++; $display("FAIL preempt_next: got gntn %b owner %0d expected gntn 0111 owner 3", gntn, owner);
    end
    reqn = 4'b1111;
    tick();
    tick();
  endtask

  task automatic test_reset_busy();
    do_reset();
    reqn = 4'b1110;
    tick();
    framen = 1'b0;
    tick();
    reqn = 4'b1001; rst = 1'b1;
    tick();
    checks++; if (gntn !== 4'b1111 || state !== 2'd0 || bus_busy !== 1'b0) begin
      errors++; $display("FAIL rst_busy: got gntn %b state %0d bus_busy %b expected 1111 0 0", gntn, state, bus_busy);
    end
    rst = 1'b0; framen = 1'b1;
    tick();
    checks++; if (gntn !== 4'b1101 || owner !== 2'd1) begin
      errors++; $display("FAIL rst_first_grant: got gntn %b owner %0d expected gntn 1101 owner 1", gntn, owner);
    end
    reqn = 4'b1111;
    tick();
    tick();
  endtask

  task automatic test_timeout_frame();
    do_reset();
    reqn = 4'b1011;
    tick();
    for (int k = 0; k < 15; k++) tick();
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL tof_still_grant: got %0d expected 1", state); end
    framen = 1'b0;
    tick();
    checks++; if (state !== 2'd2 || gntn !== 4'b1011) begin
      errors++; $display("FAIL tof_busy: got state %0d gntn %b expected state 2 gntn 1011", state, gntn);
    end
    framen = 1'b1; reqn = 4'b1111;
    tick();
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL tof_idle: got %0d expected 0", state); end
  endtask

  task automatic test_unsolicited();
    framen = 1'b0;
    tick();
    checks++; if (state !== 2'd2 || gntn !== 4'b1111 || owner !== 2'd2) begin
      errors++; $display("FAIL unsol_busy: got state %0d gntn %b owner %0d expected 2 1111 2", state, gntn, owner);
    end
    framen = 1'b1;
    tick();
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL unsol_idle: got %0d expected 0", state); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_timeout();
    test_preempt();
    test_reset_busy();
    test_timeout_frame();
    test_unsolicited();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
